// File: rtl/move_select_pkg.sv
// ---------------------------------------------------------------------------
// move_select_pkg : chess piece codes, board geometry and move_select states
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package move_select_pkg;

  localparam int SQ_BITS    = 6;
  localparam int PIECE_BITS = 4;

  localparam logic [3:0] EMPTY  = 4'h0;
  localparam logic [3:0] PAWN   = 4'h1;
  localparam logic [3:0] KNIGHT = 4'h2;
  localparam logic [3:0] BISHOP = 4'h3;
  localparam logic [3:0] ROOK   = 4'h4;
  localparam logic [3:0] QUEEN  = 4'h5;
  localparam logic [3:0] KING   = 4'h6;

  localparam int   COLOUR_BIT = 3;
  localparam logic WHITE      = 1'b0;
  localparam logic BLACK      = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_RD_SRC = 4'd1,
    ST_WT_SRC = 4'd2,
    ST_HELD   = 4'd3,
    ST_RD_DST = 4'd4,
    ST_WT_DST = 4'd5,
    ST_CHECK  = 4'd6,
    ST_WR_DST = 4'd7,
    ST_WR_SRC = 4'd8,
    ST_DONE   = 4'd9
  } state_e;

endpackage

`default_nettype wire

// File: rtl/move_select.sv
// ---------------------------------------------------------------------------
// move_select : player-move sequencer feeding the colour and rule checkers
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module move_select #(
  parameter int SQ_BITS    = 6,
  parameter int PIECE_BITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SQ_BITS-1:0]    cursor,
  input  logic                  select,
  input  logic                  cancel,
  output logic [SQ_BITS-1:0]    boardAddr,
  input  logic [PIECE_BITS-1:0] boardRdData,
  output logic                  boardWrEn,
  output logic [PIECE_BITS-1:0] boardWrData,
  output logic [PIECE_BITS-1:0] currentPiece,
  output logic [PIECE_BITS-1:0] targetPiece,
  input  logic                  allowColour,
  input  logic                  allowRule,
  output logic [SQ_BITS-1:0]    srcSq,
  output logic [SQ_BITS-1:0]    dstSq,
  output logic                  turn,
  output logic                  srcHeld,
  output logic                  moveDone,
  output logic                  illegal
);

  import move_select_pkg::*;

  state_e                state_q;
  logic [SQ_BITS-1:0]    src_q;
  logic [SQ_BITS-1:0]    dst_q;
  logic [SQ_BITS-1:0]    addr_q;
  logic [PIECE_BITS-1:0] cur_q;
  logic [PIECE_BITS-1:0] tgt_q;
  logic [PIECE_BITS-1:0] wr_data_q;
  logic                  wr_en_q;
  logic                  turn_q;
  logic                  held_q;
  logic                  done_q;
  logic                  illegal_q;
  logic                  src_bad;

  // A source is unusable if the square is empty or holds the opponent's piece.
  assign src_bad = (boardRdData == '0) || (boardRdData[PIECE_BITS-1] != turn_q);

  // Outputs are registered alongside the state transition so each one is
  // valid for exactly the cycle the FSM spends in the matching state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      addr_q    <= '0;
      cur_q     <= '0;
      tgt_q     <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      turn_q    <= 1'b0;
      held_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          held_q <= 1'b0;
          if (select) begin
            src_q   <= cursor;
            addr_q  <= cursor;
            state_q <= ST_RD_SRC;
          end
        end
        ST_RD_SRC: state_q <= ST_WT_SRC;
        ST_WT_SRC: begin
          cur_q <= boardRdData;
          if (src_bad) begin
            illegal_q <= 1'b1;
            state_q   <= ST_IDLE;
          end else begin
            held_q  <= 1'b1;
            state_q <= ST_HELD;
          end
        end
        ST_HELD: begin
          if (cancel || (select && (cursor == src_q))) begin
            held_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (select) begin
            held_q  <= 1'b0;
            dst_q   <= cursor;
            addr_q  <= cursor;
            state_q <= ST_RD_DST;
          end
        end
        ST_RD_DST: state_q <= ST_WT_DST;
        ST_WT_DST: begin
          tgt_q   <= boardRdData;
          state_q <= ST_CHECK;
        end
        ST_CHECK: begin
          if (allowColour && allowRule) begin
            addr_q    <= dst_q;
            wr_en_q   <= 1'b1;
            wr_data_q <= cur_q;
            state_q   <= ST_WR_DST;
          end else begin
            illegal_q <= 1'b1;
            tgt_q     <= '0;
            held_q    <= 1'b1;
            state_q   <= ST_HELD;
          end
        end
        ST_WR_DST: begin
          addr_q  <= src_q;
          wr_en_q <= 1'b1;
          state_q <= ST_WR_SRC;
        end
        ST_WR_SRC: begin
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          turn_q  <= ~turn_q;
          cur_q   <= '0;
          tgt_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign boardAddr    = addr_q;
  assign boardWrEn    = wr_en_q;
  assign boardWrData  = wr_data_q;
  assign currentPiece = cur_q;
  assign targetPiece  = tgt_q;
  assign srcSq        = src_q;
  assign dstSq        = dst_q;
  assign turn         = turn_q;
  assign srcHeld      = held_q;
  assign moveDone     = done_q;
  assign illegal      = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_move_select.sv
// ---------------------------------------------------------------------------
// tb_move_select : directed self-checking bench with a synchronous board RAM
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_move_select;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] cursor;
  logic       select;
  logic       cancel;
  logic [5:0] boardAddr;
  logic [3:0] boardRdData;
  logic       boardWrEn;
  logic [3:0] boardWrData;
  logic [3:0] currentPiece;
  logic [3:0] targetPiece;
  logic       allowColour;
  logic       allowRule;
  logic [5:0] srcSq;
  logic [5:0] dstSq;
  logic       turn;
  logic       srcHeld;
  logic       moveDone;
  logic       illegal;

  logic [3:0] board [64];
  logic       pre_en;
  logic [5:0] pre_addr;
  logic [3:0] pre_data;
  logic       log_clr;
  int         wr_count;
  int         md_count;
  logic [5:0] wl_addr [8];
  logic [3:0] wl_data [8];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  move_select #(.SQ_BITS(6), .PIECE_BITS(4)) dut (
    .clk(clk), .reset(reset), .cursor(cursor), .select(select), .cancel(cancel),
    .boardAddr(boardAddr), .boardRdData(boardRdData), .boardWrEn(boardWrEn),
    .boardWrData(boardWrData), .currentPiece(currentPiece), .targetPiece(targetPiece),
    .allowColour(allowColour), .allowRule(allowRule), .srcSq(srcSq), .dstSq(dstSq),
    .turn(turn), .srcHeld(srcHeld), .moveDone(moveDone), .illegal(illegal)
  );

  // Board RAM: one-cycle read latency, write captured on the clock edge.
  always @(posedge clk) begin
    if (pre_en) board[pre_addr] <= pre_data;
    else if (boardWrEn) board[boardAddr] <= boardWrData;
    boardRdData <= board[boardAddr];
  end

  always @(posedge clk) begin
    if (log_clr) begin
      wr_count <= 0;
      md_count <= 0;
    end else begin
      if (boardWrEn) begin
        wl_addr[wr_count[2:0]] <= boardAddr;
        wl_data[wr_count[2:0]] <= boardWrData;
        wr_count <= wr_count + 1;
      end
      if (moveDone) md_count <= md_count + 1;
    end
  end

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic preload(input logic [5:0] a, input logic [3:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    cyc();
    pre_en = 1'b0;
  endtask

  task automatic pulse_sel(input logic [5:0] sq);
    cursor = sq; select = 1'b1;
    cyc();
    select = 1'b0;
  endtask

  task automatic clear_logs();
    log_clr = 1'b1;
    cyc();
    log_clr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cursor = '0; select = 1'b0; cancel = 1'b0;
    allowColour = 1'b1; allowRule = 1'b1;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0; log_clr = 1'b1;
    for (int i = 0; i < 64; i++) begin
      pre_en = 1'b1; pre_addr = 6'(i); pre_data = 4'h0;
      cyc();
    end
    pre_en = 1'b0;
    cyc(2);

    // Reset state
    check("rst_turn", 32'(turn), 32'd0);
    check("rst_srcHeld", 32'(srcHeld), 32'd0);
    check("rst_wrEn", 32'(boardWrEn), 32'd0);
    check("rst_addr", 32'(boardAddr), 32'd0);
    check("rst_cur", 32'(currentPiece), 32'd0);
    check("rst_flags", 32'({moveDone, illegal}), 32'd0);
    reset = 1'b0;
    log_clr = 1'b0;

    // Legal move: white pawn 12 -> 28
    preload(6'd12, 4'h1);
    clear_logs();
    pulse_sel(6'd12);
    check("m1_rdsrc_addr", 32'(boardAddr), 32'd12);
    check("m1_srcSq", 32'(srcSq), 32'd12);
    cyc(2);
    check("m1_held", 32'(srcHeld), 32'd1);
    check("m1_cur", 32'(currentPiece), 32'h1);
    pulse_sel(6'd28);
    check("m1_held_drop", 32'(srcHeld), 32'd0);
    cyc(3);
    check("m1_wrdst", 32'({boardWrEn, boardAddr, boardWrData}), 32'({1'b1, 6'd28, 4'h1}));
    cyc();
    check("m1_wrsrc", 32'({boardWrEn, boardAddr, boardWrData}), 32'({1'b1, 6'd12, 4'h0}));
    check("m1_done_early", 32'(moveDone), 32'd0);
    cyc();
    check("m1_done", 32'({moveDone, boardWrEn}), 32'({1'b1, 1'b0}));
    cyc();
    check("m1_turn", 32'(turn), 32'd1);
    check("m1_cur_clr", 32'({currentPiece, targetPiece}), 32'd0);
    check("m1_board28", 32'(board[28]), 32'h1);
    check("m1_board12", 32'(board[12]), 32'h0);
    check("m1_wr_count", 32'(wr_count), 32'd2);
    check("m1_wlog0", 32'({wl_addr[0], wl_data[0]}), 32'({6'd28, 4'h1}));
    check("m1_wlog1", 32'({wl_addr[1], wl_data[1]}), 32'({6'd12, 4'h0}));
    check("m1_md_count", 32'(md_count), 32'd1);

    // Wrong-colour source with white to move
    reset = 1'b1; cyc(); reset = 1'b0;
    preload(6'd52, 4'h9);
    clear_logs();
    pulse_sel(6'd52);
    cyc();
    check("m2_no_illegal_yet", 32'(illegal), 32'd0);
    cyc();
    check("m2_illegal", 32'({illegal, srcHeld}), 32'({1'b1, 1'b0}));
    cyc();
    check("m2_illegal_1cyc", 32'(illegal), 32'd0);
    // Empty source square is also rejected
    pulse_sel(6'd0);
    cyc(2);
    check("m2_empty_illegal", 32'({illegal, srcHeld}), 32'({1'b1, 1'b0}));
    cyc();
    check("m2_no_writes", 32'(wr_count), 32'd0);

    // Colour checker refuses: source stays held
    preload(6'd3, 4'h5);
    preload(6'd11, 4'h1);
    allowColour = 1'b0;
    pulse_sel(6'd3);
    cyc(2);
    check("m3_held", 32'(srcHeld), 32'd1);
    pulse_sel(6'd11);
    cyc(2);
    check("m3_check_pieces", 32'({currentPiece, targetPiece}), 32'({4'h5, 4'h1}));
    cyc();
    check("m3_illegal", 32'({illegal, srcHeld, targetPiece}), 32'({1'b1, 1'b1, 4'h0}));
    cyc();
    check("m3_after", 32'({illegal, srcHeld, turn}), 32'({1'b0, 1'b1, 1'b0}));
    cancel = 1'b1; cyc(); cancel = 1'b0;
    check("m3_cancel", 32'(srcHeld), 32'd0);
    check("m3_no_writes", 32'(wr_count), 32'd0);
    allowColour = 1'b1;

    // Deselect by reselecting the source, then select+cancel together
    preload(6'd6, 4'h2);
    pulse_sel(6'd6);
    cyc(2);
    check("m4_held", 32'(srcHeld), 32'd1);
    pulse_sel(6'd6);
    check("m4_deselect", 32'({srcHeld, illegal}), 32'd0);
    cyc(4);
    check("m4_stays_idle", 32'({srcHeld, illegal, boardWrEn}), 32'd0);
    pulse_sel(6'd6);
    cyc(2);
    cursor = 6'd20; select = 1'b1; cancel = 1'b1;
    cyc();
    select = 1'b0; cancel = 1'b0;
    check("m4_cancel_wins", 32'(srcHeld), 32'd0);
    cyc(4);
    check("m4_cancel_idle", 32'({srcHeld, illegal, boardWrEn, dstSq}), 32'({3'b000, 6'd11}));
    check("m4_no_writes", 32'(wr_count), 32'd0);

    // Reset on the WR_DST cycle: only the destination write lands
    pulse_sel(6'd6);
    cyc(2);
    pulse_sel(6'd21);
    cyc(3);
    check("m5_wrdst", 32'({boardWrEn, boardAddr}), 32'({1'b1, 6'd21}));
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("m5_rst_outs", 32'({boardWrEn, boardAddr, boardWrData, srcSq, dstSq}), 32'd0);
    check("m5_rst_misc", 32'({currentPiece, targetPiece, turn, srcHeld, moveDone, illegal}), 32'd0);
    cyc(3);
    check("m5_one_write", 32'(wr_count), 32'd1);
    check("m5_board", 32'({board[21], board[6]}), 32'({4'h2, 4'h2}));
    check("m5_no_done", 32'(md_count), 32'd0);

    // Select pulses during RD_DST..DONE are ignored
    clear_logs();
    pulse_sel(6'd6);
    cyc(2);
    pulse_sel(6'd22);
    cursor = 6'd40; select = 1'b1;
    cyc(6);
    select = 1'b0;
    cyc(2);
    check("m6_md_count", 32'(md_count), 32'd1);
    check("m6_wr_count", 32'(wr_count), 32'd2);
    check("m6_dstSq", 32'(dstSq), 32'd22);
    check("m6_state", 32'({srcHeld, turn}), 32'({1'b0, 1'b1}));
    check("m6_board", 32'({board[22], board[6]}), 32'({4'h2, 4'h0}));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/move_select.md
Name: move_select

Overview:
- Player-move sequencer directly upstream of the colour checker.
- Takes cursor square selections and reads the source and target pieces from board RAM.
- Presents the pieces to the colour checker as currentPiece/targetPiece and samples allowColour plus a rule-check verdict.
- On a legal move, writes the board (target <- piece, source <- empty) and toggles the side to move.

Parameters:
- SQ_BITS, 6, square index width (64 squares, index = rank*8+file).
- PIECE_BITS, 4, piece code width; bit 3 = colour (0 white, 1 black), bits 2:0 = type; 4'b0000 = empty.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- cursor  input  SQ_BITS  currently highlighted square.
- select  input  1  one-cycle select pulse (debounced upstream).
- cancel  input  1  one-cycle cancel pulse.
- boardAddr  output  SQ_BITS  board RAM address.
- boardRdData  input  PIECE_BITS  board RAM read data, valid 1 cycle after boardAddr.
- boardWrEn  output  1  board RAM write strobe.
- boardWrData  output  PIECE_BITS  board RAM write data.
- currentPiece  output  PIECE_BITS  registered source piece, to the colour checker.
- targetPiece  output  PIECE_BITS  registered target piece, to the colour checker.
- allowColour  input  1  colour-checker verdict (combinational from currentPiece/targetPiece).
- allowRule  input  1  movement-rule verdict for srcSq/dstSq/currentPiece.
- srcSq  output  SQ_BITS  latched source square.
- dstSq  output  SQ_BITS  latched target square.
- turn  output  1  side to move (0 white, 1 black).
- srcHeld  output  1  high while a source is selected (for display highlight).
- moveDone  output  1  one-cycle pulse on a committed move.
- illegal  output  1  one-cycle pulse on a rejected selection or move.

Behaviour:
- Reset (synchronous, dominates all other inputs):
  - State returns to IDLE.
  - turn=0; srcSq=dstSq=0; currentPiece=targetPiece=0.
  - boardAddr=0, boardWrEn=0, boardWrData=0.
  - srcHeld=moveDone=illegal=0.
  - A reset mid-sequence, including during WR_DST, aborts with no further writes.
- States and transitions:
  - IDLE: on select, latch srcSq<=cursor -> RD_SRC. cancel is ignored.
  - RD_SRC: boardAddr=srcSq -> WT_SRC.
  - WT_SRC: currentPiece<=boardRdData.
    - If the piece is empty or colour!=turn: illegal pulse -> IDLE.
    - Otherwise -> HELD.
  - HELD: srcHeld=1.
    - cancel -> IDLE (cancel wins over a simultaneous select).
    - select with cursor==srcSq -> IDLE silently (deselect).
    - select otherwise: latch dstSq<=cursor -> RD_DST.
  - RD_DST: boardAddr=dstSq -> WT_DST.
  - WT_DST: targetPiece<=boardRdData -> CHECK.
  - CHECK: both piece registers are stable, so sample allowColour & allowRule this cycle.
    - Both 1 -> WR_DST.
    - Otherwise illegal pulse, targetPiece<=0 -> HELD (source stays selected for a retry).
  - WR_DST: boardAddr=dstSq, boardWrEn=1, boardWrData=currentPiece -> WR_SRC.
  - WR_SRC: boardAddr=srcSq, boardWrEn=1, boardWrData=0 -> DONE.
  - DONE: moveDone=1; turn<=~turn; currentPiece<=0; targetPiece<=0 -> IDLE.
- Timing and handshake:
  - select/cancel are only sampled in IDLE and HELD; pulses arriving in other states are dropped.
  - Latency: select sampled in HELD at cycle t gives writes at t+4 and t+5, and moveDone at t+6.
  - boardWrEn is high for exactly two consecutive cycles per committed move and never otherwise.
- Output registration:
  - moveDone, illegal, srcHeld and boardWrEn are decoded from registered state only.
  - No output depends combinationally on select, cancel or cursor.
- Arithmetic/width: no arithmetic; square indices are never wrapped or incremented here; colour is compared as bit PIECE_BITS-1 of the piece code.

Decomposition:
- Shared chess package: piece-code constants (EMPTY=4'h0, PAWN..KING=1..6, COLOUR_BIT=3, WHITE=0, BLACK=1), SQ_BITS, and the move_select state encoding localparams.
- No sub-module: a single FSM with datapath registers. The colour checker and rule checker stay external and are instantiated alongside this block by the top level.

Test Plan:
- Reset, then board: sq12=4'h1 (white pawn), sq28=0 -> select@12, select@28, allowColour=allowRule=1 -> writes sq28<=4'h1 then sq12<=0; moveDone pulses 6 cycles after the second select; turn=1.
- turn=0 with sq52=4'h9 (black pawn) -> select@52 -> illegal pulse 2 cycles later, state IDLE, no writes, srcHeld=0.
- Source sq3=4'h5 (white queen), target sq11=4'h1 (white pawn), allowColour=0 -> illegal pulse, srcHeld remains 1, no writes, turn unchanged.
- In HELD (src sq6), select@6 -> returns to IDLE, no illegal and no writes. Repeat with select and cancel asserted in the same cycle -> IDLE.
- Legal move in progress, reset asserted on the WR_DST cycle -> only one write occurs (sq dst); next cycle all outputs are 0, turn=0.
- Select pulses during RD_DST..DONE are ignored; exactly one moveDone and two boardWrEn cycles are observed.
